// File: rtl/avalon_stall_ram_pkg.sv
// rtl/avalon_stall_ram_pkg.sv - shared types, defaults and address helper for the stall RAM
package avalon_stall_ram_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam int    DEF_DEPTH_WORDS = 256;
    localparam int    DEF_WAIT_CYCLES = 2;
    localparam word_t DEF_BASE_ADDR   = 32'hBFC0_0000;

    // Word offset from the base before any wrap; the error check needs the unwrapped value.
    function automatic word_t raw_word_index(input word_t addr, input word_t base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/avalon_stall_ram_if.sv
// rtl/avalon_stall_ram_if.sv - Avalon-MM bus bundle; carries err when STALL_RAM_ERR_EN is defined
interface avalon_stall_ram_if;
    import avalon_stall_ram_pkg::*;

    word_t      address;
    logic       read;
    logic       write;
    word_t      writedata;
    logic [3:0] byteenable;
    logic       waitrequest;
    word_t      readdata;
`ifdef STALL_RAM_ERR_EN
    logic       err;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, err
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, err
    );
`else
    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
`endif

endinterface

// File: rtl/stall_ram_array.sv
// rtl/stall_ram_array.sv - byte-lane writable word storage, one write port, one registered read port
module stall_ram_array
    import avalon_stall_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  word_t            wr_data,
    input  logic             re,
    input  logic [IDX_W-1:0] rd_idx,
    output word_t            rd_data
);

    word_t mem [DEPTH_WORDS];

    // Storage is deliberately not reset so preloaded contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/avalon_stall_ram.sv
// rtl/avalon_stall_ram.sv - Avalon-MM RAM with fixed wait states; STALL_RAM_ERR_EN adds the err flag
module avalon_stall_ram
    import avalon_stall_ram_pkg::*;
#(
    parameter int    DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int    WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter word_t BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    avalon_stall_ram_if.slave   bus,
    input  logic                load_en,
    input  logic [7:0]          load_addr,
    input  word_t               load_data
);

    localparam int    IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam word_t DEPTH_W = word_t'(DEPTH_WORDS);

    function automatic logic [IDX_W-1:0] wrap_idx(input word_t w);
        return IDX_W'(w % DEPTH_W);
    endfunction

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [IDX_W-1:0] lat_idx;
    word_t            lat_data;
    logic [3:0]       lat_be;
    logic             lat_write;
    logic             req;
    logic             start;
    logic             wait_req;
    word_t            bus_raw;
    logic [IDX_W-1:0] bus_idx;

    logic             mem_we, mem_re;
    logic [IDX_W-1:0] mem_wr_idx, mem_rd_idx;
    logic [3:0]       mem_wr_be;
    word_t            mem_wr_data, mem_rd_data;

    assign req     = bus.read | bus.write;
    assign start   = (state == ST_IDLE) && req && !load_en;
    assign bus_raw = raw_word_index(bus.address, BASE_ADDR);
    assign bus_idx = wrap_idx(bus_raw);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (load_en) begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_nx = ST_ACK;
                            cnt_nx   = 4'd0;
                        end else begin
                            state_nx = ST_STALL;
                            cnt_nx   = 4'(WAIT_CYCLES);
                        end
                    end
                end
                ST_STALL: begin
                    // A master that gives up mid-stall gets no access at all.
                    if (!req) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = 4'd0;
                    end else if (cnt <= 4'd1) begin
                        state_nx = ST_ACK;
                        cnt_nx   = 4'd0;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        wait_req = 1'b0;
        if (load_en) begin
            wait_req = 1'b1;
        end else begin
            case (state)
                ST_IDLE:  wait_req = req;
                ST_STALL: wait_req = 1'b1;
                default:  wait_req = 1'b0;
            endcase
        end
    end

    assign bus.waitrequest = wait_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_idx   <= '0;
            lat_data  <= '0;
            lat_be    <= 4'h0;
            lat_write <= 1'b0;
        end else if (start) begin
            lat_idx   <= bus_idx;
            lat_data  <= bus.writedata;
            lat_be    <= bus.byteenable;
            lat_write <= bus.write;
        end
    end

    // Preload shares the write port and wins; it also forces the FSM out of any access.
    assign mem_we      = load_en | ((state == ST_ACK) && lat_write && !reset);
    assign mem_wr_idx  = load_en ? wrap_idx(word_t'(load_addr) >> 2) : lat_idx;
    assign mem_wr_be   = load_en ? 4'hF : lat_be;
    assign mem_wr_data = load_en ? load_data : lat_data;

    // The read register loads on the edge into ACK so data is already valid during ACK.
    assign mem_re     = !reset && (state_nx == ST_ACK) &&
                        ((state == ST_IDLE) ? !bus.write : !lat_write);
    assign mem_rd_idx = (state == ST_IDLE) ? bus_idx : lat_idx;

    stall_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .wr_idx  (mem_wr_idx),
        .wr_be   (mem_wr_be),
        .wr_data (mem_wr_data),
        .re      (mem_re),
        .rd_idx  (mem_rd_idx),
        .rd_data (mem_rd_data)
    );

    assign bus.readdata = mem_rd_data;

`ifdef STALL_RAM_ERR_EN
    logic lat_err;
    logic err_cond;

    assign err_cond = (bus.address[1:0] != 2'b00) || (bus_raw >= DEPTH_W) ||
                      (bus.read && bus.write);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_err <= 1'b0;
        end else if (start) begin
            lat_err <= err_cond;
        end
    end

    assign bus.err = (state == ST_ACK) && lat_err;
`endif

endmodule

// File: doc/avalon_stall_ram.md
AVALON_STALL_RAM -- requirements
Module: avalon_stall_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 Parameter WAIT_CYCLES, default 2: extra stall cycles per bus access, range 0..15.
REQ-003 Parameter BASE_ADDR, default 32'hBFC00000: byte address that maps to word 0.
REQ-004 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port address, input, 32: Avalon byte address from the CPU master.
REQ-007 Port read, input, 1: Avalon read request.
REQ-008 Port write, input, 1: Avalon write request.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port byteenable, input, 4: byte-lane enables; bit n covers writedata[8n+7:8n].
REQ-011 Port waitrequest, output, 1: high means the current request has not completed.
REQ-012 Port readdata, output, 32: read result, valid in the completing cycle.
REQ-013 Port load_en, input, 1: testbench preload strobe.
REQ-014 Port load_addr, input, 8: preload byte offset from BASE_ADDR.
REQ-015 Port load_data, input, 32: preload word.

Function
REQ-016 Word index SHALL be ((address - BASE_ADDR) >> 2) modulo DEPTH_WORDS; address[1:0] is ignored.
REQ-017 The FSM SHALL have three states: IDLE, STALL and ACK.
REQ-018 IDLE with read or write high SHALL latch address, writedata, byteenable and operation. It then goes to STALL with counter = WAIT_CYCLES, or to ACK if WAIT_CYCLES = 0.
REQ-019 STALL SHALL decrement the counter each cycle and go to ACK in the cycle after the counter reaches 0.
REQ-020 waitrequest SHALL be combinational: high in IDLE when read or write is high, high in STALL, and low in ACK and in idle IDLE.
REQ-021 Access latency SHALL be exactly WAIT_CYCLES+1 waitrequest-high cycles, followed by one ACK cycle with waitrequest low.
REQ-022 In ACK, a latched write SHALL commit only the enabled byte lanes at the end of the cycle.
REQ-023 In ACK, a latched read SHALL present the addressed word on readdata from a register.
REQ-024 readdata SHALL hold its value until the next read ACK.
REQ-025 ACK SHALL always return to IDLE; back-to-back requests therefore restart at REQ-018.
REQ-026 If read and write are both high at request start, the write SHALL take priority and readdata SHALL be unchanged.
REQ-027 If read and write both drop while in STALL, the FSM SHALL return to IDLE next cycle with no memory access.
REQ-028 Changes to address or data during STALL SHALL be ignored, because latched values are used.
REQ-029 load_en high SHALL write load_data to word (load_addr >> 2) at the clock edge.
REQ-030 While load_en is high, the FSM SHALL be held in IDLE and waitrequest forced high.
REQ-031 A write with byteenable = 4'b0000 SHALL complete the handshake and leave memory unchanged.

Reset
REQ-032 When reset is high at an edge: state = IDLE, counter = 0, readdata = 32'h0, and the error flag (if present) = 0.
REQ-033 Memory contents SHALL be preserved across reset.
REQ-034 Reset during STALL or ACK SHALL abort the access; no write commits in that cycle.

Configuration
REQ-035 With STALL_RAM_ERR_EN defined, an output port err (1 bit) SHALL exist.
REQ-036 With STALL_RAM_ERR_EN, err SHALL pulse high in ACK for: misaligned address (address[1:0] != 0), word index >= DEPTH_WORDS before wrap, or simultaneous read and write. The access still proceeds per REQ-016/REQ-026.
REQ-037 Without STALL_RAM_ERR_EN, there SHALL be no err port and no error logic.

Structure
REQ-038 Package avalon_stall_ram_pkg SHALL hold the FSM state enum, the 32-bit word typedef and the default constants for DEPTH_WORDS, WAIT_CYCLES and BASE_ADDR.
REQ-039 Sub-module stall_ram_array SHALL implement the byte-lane-writable storage, with one write port shared by the bus and preload and one registered read port.

Verification
REQ-040 Scenario: preload word 0x04 = 32'h240300FF, then read 0xBFC00004 with WAIT_CYCLES=2 -> waitrequest high for 3 cycles, then low for 1 cycle with readdata = 32'h240300FF.
REQ-041 Scenario: write 32'hAABBCCDD with byteenable 4'b0101 to a word holding 32'h11223344, then read it back -> 32'h11BB33DD.
REQ-042 Scenario: WAIT_CYCLES=0, back-to-back reads of 0xBFC00008 and 0xBFC0000C -> each read has 1 stall cycle and 1 ACK cycle, with correct data and no lost request.
REQ-043 Scenario: read issued, then dropped after 1 stall cycle -> FSM returns to IDLE, readdata unchanged, no ACK cycle.
REQ-044 Scenario: reset asserted during STALL of a write of 32'hDEADBEEF -> memory keeps the old value, readdata = 0, waitrequest low once read/write are low.
REQ-045 Scenario (with STALL_RAM_ERR_EN): read at 0xBFC00006 -> err = 1 in the ACK cycle, and readdata = word 0xBFC00004.
